encoder4to2_stream: RTL and testbench

//   Registered 4-to-2 encoder: the inverse of the team's 2-to-4 decoder.

---
 rtl/encoder4to2_stream.sv | 127 ++++++++++++
 tb/tb_encoder4to2_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/encoder4to2_stream.sv
// Registered 4-to-2 encoder with a 2-entry valid/ready output buffer and a saturating count of non-one-hot words.
// Optional macro ROUND_ROBIN_EN: multi-hot words use a rotating priority pointer instead of highest-index priority.
module encoder4to2_stream #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       y,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned DEPTH_W = 2;

    typedef struct packed {
        logic [1:0] idx;
        logic       err;
    } entry_t;

    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    entry_t               enc_c;
    logic [DEPTH_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [2:0]           ones_c;
    logic                 push_c;
    logic                 pop_c;

    assign in_ready  = (count_q < DEPTH_W'(2));
    assign out_valid = (count_q != DEPTH_W'(0));
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;
    assign y         = head_q.idx;
    assign out_err   = head_q.err;
    assign err_cnt   = err_cnt_q;

    assign ones_c = 3'(i[0]) + 3'(i[1]) + 3'(i[2]) + 3'(i[3]);

`ifdef ROUND_ROBIN_EN
    logic [1:0] rr_q, rr_d;
    logic [1:0] rr_idx_c;
    logic       multi_hot_c;

    assign multi_hot_c = (ones_c > 3'd1);

    // Encoder: one-hot/zero words as fixed priority, multi-hot searched from rr_q upward.
    always_comb begin
        enc_c     = '0;
        rr_idx_c  = '0;
        enc_c.err = (ones_c != 3'd1);
        if (i[3])      enc_c.idx = 2'd3;
        else if (i[2]) enc_c.idx = 2'd2;
        else if (i[1]) enc_c.idx = 2'd1;
        else           enc_c.idx = 2'd0;
        if (multi_hot_c) begin
            // Descending scan so the closest set bit to rr_q is written last.
            for (int k = 3; k >= 0; k--) begin
                rr_idx_c = rr_q + 2'(k);
                if (i[rr_idx_c]) enc_c.idx = rr_idx_c;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (push_c && multi_hot_c) rr_d = enc_c.idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
`else
    // Encoder: highest set bit wins; zero maps to index 0.
    always_comb begin
        enc_c     = '0;
        enc_c.err = (ones_c != 3'd1);
        if (i[3])      enc_c.idx = 2'd3;
        else if (i[2]) enc_c.idx = 2'd2;
        else if (i[1]) enc_c.idx = 2'd1;
        else           enc_c.idx = 2'd0;
    end
`endif

    // Buffer next state; head holds its value after the last pop.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        case ({push_c, pop_c})
            2'b10: begin
                if (count_q == DEPTH_W'(0)) head_d = enc_c;
                else                        tail_d = enc_c;
                count_d = count_q + DEPTH_W'(1);
            end
            2'b01: begin
                if (count_q == DEPTH_W'(2)) head_d = tail_q;
                count_d = count_q - DEPTH_W'(1);
            end
            2'b11: head_d = enc_c;
            default: ;
        endcase
        if (push_c && enc_c.err && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_encoder4to2_stream.sv
// Scoreboard bench for encoder4to2_stream; a second instance with CNT_W=2 checks counter saturation.
module tb_encoder4to2_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] i;
    logic       out_ready;
    logic       in_ready,  out_valid,  out_err;
    logic [1:0] y;
    logic [7:0] err_cnt;
    logic       in_ready_s, out_valid_s, out_err_s;
    logic [1:0] y_s;
    logic [1:0] err_cnt_s;

    encoder4to2_stream #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .i(i),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_err(out_err), .err_cnt(err_cnt)
    );

    encoder4to2_stream #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .i(i),
        .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .out_err(out_err_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] y;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         mcount   = 0;
    logic [1:0] mp       = 2'd0;
    int         ecnt8    = 0;
    int         ecnt2    = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder; advances the model pointer on multi-hot words when rotating.
    function automatic exp_t model_enc(input logic [3:0] w);
        exp_t e;
        int   ones;
        int   idx;
        ones  = 0;
        for (int k = 0; k < 4; k++) if (w[k]) ones++;
        e.err = (ones != 1);
        e.y   = 2'd0;
        if (RR && ones > 1) begin
            for (int k = 3; k >= 0; k--) begin
                idx = (int'(mp) + k) % 4;
                if (w[idx]) e.y = 2'(idx);
            end
            mp = e.y + 2'd1;
        end else begin
            for (int k = 0; k < 4; k++) if (w[k]) e.y = 2'(k);
        end
        return e;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; i = 4'd0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        mcount = 0; mp = 2'd0; ecnt8 = 0; ecnt2 = 0;
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(0));
        chk({tag, ".in_ready"},  16'(in_ready),  16'(1));
        chk({tag, ".y"},         16'(y),         16'(0));
        chk({tag, ".out_err"},   16'(out_err),   16'(0));
        chk({tag, ".err_cnt"},   16'(err_cnt),   16'(0));
        chk({tag, ".err_cnt_s"}, 16'(err_cnt_s), 16'(0));
    endtask

    task automatic cycle(input logic iv, input logic [3:0] w, input logic ordy, input string tag);
        exp_t e;
        exp_t h;
        int   pushed;
        int   popped;
        @(negedge clk);
        rst = 1'b0; in_valid = iv; i = w; out_ready = ordy;
        #1;
        pushed = 0;
        popped = 0;
        chk({tag, ".in_ready"},  16'(in_ready),  16'(mcount < 2));
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(mcount != 0));
        if (mcount != 0 && ordy) begin
            popped = 1;
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 16'(0), 16'(1));
            end else begin
                h = sb.pop_front();
                chk({tag, ".y"},       16'(y),       16'(h.y));
                chk({tag, ".out_err"}, 16'(out_err), 16'(h.err));
            end
        end
        if (iv && mcount < 2) begin
            pushed = 1;
            e = model_enc(w);
            sb.push_back(e);
            if (e.err) begin
                if (ecnt8 < 255) ecnt8++;
                if (ecnt2 < 3)   ecnt2++;
            end
        end
        mcount = mcount + pushed - popped;
        @(posedge clk);
        #1;
        chk({tag, ".err_cnt"},   16'(err_cnt),   16'(ecnt8));
        chk({tag, ".err_cnt_s"}, 16'(err_cnt_s), 16'(ecnt2));
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 4; n++) cycle(1'b0, 4'd0, 1'b1, tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; i = 4'd0; out_ready = 1'b0;
        do_reset("rst0");

        // One-hot stream with consumer always ready.
        cycle(1'b1, 4'b0001, 1'b1, "t1");
        cycle(1'b1, 4'b0010, 1'b1, "t1");
        cycle(1'b1, 4'b0100, 1'b1, "t1");
        cycle(1'b1, 4'b1000, 1'b1, "t1");
        drain("t1d");

        // Fill the buffer under backpressure, third word is refused.
        cycle(1'b1, 4'b0100, 1'b0, "t2");
        cycle(1'b1, 4'b1000, 1'b0, "t2");
        cycle(1'b1, 4'b0001, 1'b0, "t2full");
        cycle(1'b1, 4'b0001, 1'b0, "t2hold");
        cycle(1'b0, 4'b0000, 1'b1, "t2pop");
        cycle(1'b0, 4'b0000, 1'b1, "t2pop");
        drain("t2d");

        // Multi-hot and zero words.
        cycle(1'b1, 4'b1010, 1'b1, "t3");
        cycle(1'b1, 4'b0000, 1'b1, "t3");
        cycle(1'b1, 4'b0110, 1'b1, "t3");
        drain("t3d");

        // Counter saturation on the narrow instance.
        do_reset("rst4");
        for (int n = 0; n < 5; n++) cycle(1'b1, 4'b1111, 1'b1, "t4");
        drain("t4d");

        // Steady push+pop at count 1, then reset mid-stream.
        do_reset("rst5a");
        cycle(1'b1, 4'b0001, 1'b1, "t5");
        cycle(1'b1, 4'b0010, 1'b1, "t5");
        cycle(1'b1, 4'b1100, 1'b1, "t5");
        cycle(1'b1, 4'b1000, 1'b1, "t5");
        cycle(1'b1, 4'b0100, 1'b1, "t5");
        do_reset("rst5b");
        cycle(1'b0, 4'b0000, 1'b1, "t5post");

        // Repeated all-ones words: rotation visible only with the rotating priority build.
        do_reset("rst6");
        for (int n = 0; n < 4; n++) cycle(1'b1, 4'b1111, 1'b1, "t6");
        cycle(1'b1, 4'b0100, 1'b1, "t6oh");
        cycle(1'b1, 4'b1111, 1'b1, "t6wrap");
        cycle(1'b1, 4'b0101, 1'b1, "t6mh");
        drain("t6d");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
